// File: rtl/regfile_arb_pkg.sv
// Shared encodings and default sizes for the register-file port arbiter.
package regfile_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 5;

  // Which register-file read port serves a granted read.
  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_R1   = 2'd1,
    PORT_R2   = 2'd2
  } port_sel_t;

  // Wrap a rotated requester index back into 0..n-1.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_scan.sv
// Rotating-priority scan: decides which requesters are granted this cycle
// and which read port each granted read uses, never pairing a write with a
// read of the same address.
module rr_scan
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int PTR_W      = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [PTR_W-1:0]              rr_ptr,
  output logic [NUM_REQ-1:0]            grant,
  output logic [2*NUM_REQ-1:0]          rd_port,
  output logic                          wr_gnt,
  output logic [PTR_W-1:0]              wr_idx,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic                          rd1_used,
  output logic [ADDR_WIDTH-1:0]         rd1_addr,
  output logic                          rd2_used,
  output logic [ADDR_WIDTH-1:0]         rd2_addr,
  output logic                          any_gnt,
  output logic [PTR_W-1:0]              last_idx
);

  int                    idx;
  logic [ADDR_WIDTH-1:0] cur_addr;

  // Walk requesters from rr_ptr onward, handing out the write slot and the two read ports.
  always_comb begin
    grant    = '0;
    rd_port  = '0;
    wr_gnt   = 1'b0;
    wr_idx   = '0;
    wr_addr  = '0;
    rd1_used = 1'b0;
    rd1_addr = '0;
    rd2_used = 1'b0;
    rd2_addr = '0;
    any_gnt  = 1'b0;
    last_idx = '0;
    idx      = 0;
    cur_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx      = wrap_idx(int'(rr_ptr) + k, NUM_REQ);
      cur_addr = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
      if (req_valid[idx]) begin
        if (req_we[idx]) begin
          // A write must not hit an address already being read this cycle.
          if (!wr_gnt && !(rd1_used && (rd1_addr == cur_addr))
                      && !(rd2_used && (rd2_addr == cur_addr))) begin
            grant[idx] = 1'b1;
            wr_gnt     = 1'b1;
            wr_idx     = PTR_W'(idx);
            wr_addr    = cur_addr;
            any_gnt    = 1'b1;
            last_idx   = PTR_W'(idx);
          end else begin
            grant[idx] = 1'b0;
          end
        end else if (wr_gnt && (wr_addr == cur_addr)) begin
          // Reading the address being written would collide; wait a cycle.
          grant[idx] = 1'b0;
        end else if (rd1_used && (rd1_addr == cur_addr)) begin
          grant[idx]         = 1'b1;
          rd_port[2*idx +: 2] = PORT_R1;
          any_gnt            = 1'b1;
          last_idx           = PTR_W'(idx);
        end else if (rd2_used && (rd2_addr == cur_addr)) begin
          grant[idx]         = 1'b1;
          rd_port[2*idx +: 2] = PORT_R2;
          any_gnt            = 1'b1;
          last_idx           = PTR_W'(idx);
        end else if (!rd1_used) begin
          grant[idx]         = 1'b1;
          rd_port[2*idx +: 2] = PORT_R1;
          rd1_used           = 1'b1;
          rd1_addr           = cur_addr;
          any_gnt            = 1'b1;
          last_idx           = PTR_W'(idx);
        end else if (!rd2_used) begin
          grant[idx]         = 1'b1;
          rd_port[2*idx +: 2] = PORT_R2;
          rd2_used           = 1'b1;
          rd2_addr           = cur_addr;
          any_gnt            = 1'b1;
          last_idx           = PTR_W'(idx);
        end else begin
          grant[idx] = 1'b0;
        end
      end else begin
        grant[idx] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares a 2-read/1-write register file among NUM_REQ requesters with
// round-robin priority and routes read data back to its owners.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  output logic [DATA_WIDTH-1:0]         rf_din,
  output logic [ADDR_WIDTH-1:0]         rf_wad1,
  output logic [ADDR_WIDTH-1:0]         rf_rad1,
  output logic [ADDR_WIDTH-1:0]         rf_rad2,
  output logic                          rf_wen1,
  output logic                          rf_ren1,
  output logic                          rf_ren2,
  input  logic [DATA_WIDTH-1:0]         rf_dout1,
  input  logic [DATA_WIDTH-1:0]         rf_dout2,
  input  logic                          rf_collision,
  output logic                          collision_err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  port_sel_t             rsp_port_q [NUM_REQ];
  port_sel_t             rsp_port_d [NUM_REQ];
  logic                  collision_err_q, collision_err_d;

  logic [NUM_REQ-1:0]    scan_valid;
  logic [NUM_REQ-1:0]    grant;
  logic [2*NUM_REQ-1:0]  rd_port;
  logic                  wr_gnt;
  logic [PTR_W-1:0]      wr_idx;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd1_used, rd2_used;
  logic [ADDR_WIDTH-1:0] rd1_addr, rd2_addr;
  logic                  any_gnt;
  logic [PTR_W-1:0]      last_idx;

  // Nothing is granted while reset is held, so no partial grant can escape.
  assign scan_valid = req_valid & {NUM_REQ{resetn}};

  rr_scan #(
    .NUM_REQ   (NUM_REQ),
    .ADDR_WIDTH(ADDR_WIDTH),
    .PTR_W     (PTR_W)
  ) u_scan (
    .req_valid(scan_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .rr_ptr   (rr_ptr_q),
    .grant    (grant),
    .rd_port  (rd_port),
    .wr_gnt   (wr_gnt),
    .wr_idx   (wr_idx),
    .wr_addr  (wr_addr),
    .rd1_used (rd1_used),
    .rd1_addr (rd1_addr),
    .rd2_used (rd2_used),
    .rd2_addr (rd2_addr),
    .any_gnt  (any_gnt),
    .last_idx (last_idx)
  );

  // Drive the register file from this cycle's grants; idle fields stay zero.
  always_comb begin
    req_ready = grant;
    rf_wen1   = wr_gnt;
    rf_wad1   = wr_addr;
    rf_ren1   = rd1_used;
    rf_rad1   = rd1_addr;
    rf_ren2   = rd2_used;
    rf_rad2   = rd2_addr;
    if (wr_gnt) begin
      rf_din = req_wdata[wr_idx*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      rf_din = '0;
    end
  end

  // Next pointer follows the last granted requester; sticky collision flag.
  always_comb begin
    if (any_gnt) begin
      if (last_idx == PTR_W'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = last_idx + PTR_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    collision_err_d = collision_err_q | rf_collision;
  end

  // Remember which read port each granted reader was given.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i] && !req_we[i]) begin
        rsp_port_d[i] = port_sel_t'(rd_port[2*i +: 2]);
      end else begin
        rsp_port_d[i] = PORT_NONE;
      end
    end
  end

  // Steer the register file's read data to the requesters granted last cycle.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      case (rsp_port_q[i])
        PORT_R1: begin
          rsp_valid[i]                         = 1'b1;
          rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = rf_dout1;
        end
        PORT_R2: begin
          rsp_valid[i]                         = 1'b1;
          rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = rf_dout2;
        end
        default: begin
          rsp_valid[i]                         = 1'b0;
          rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
      endcase
    end
  end

  assign collision_err = collision_err_q;

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr_q        <= '0;
      collision_err_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_port_q[i] <= PORT_NONE;
      end
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      collision_err_q <= collision_err_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_port_q[i] <= rsp_port_d[i];
      end
    end
  end

endmodule
